dm_responder: RTL and testbench
===============================

# dm_responder

Multi-cycle data-memory responder: the memory-side end of the CPU's data-memory port. It accepts one load/store request at a time over a valid/ready handshake, spends a fixed number of wait states, then returns a response over a second valid/ready handshake. It supports word and byte accesses on a 1 KiB big-endian byte-addressed store. It replaces the single-cycle data memory when the controller is built to stall on memory.

## Interface
Parameters:
- ADDR_W, 10: byte-address width; storage is 2**ADDR_W bytes, organised as 2**(ADDR_W-2) words.
- WAIT_CYCLES, 2: wait states between request accept and response; legal range 0..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = word access.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; a byte store uses bits [7:0].
- rsp_valid  out  1  response present; held until accepted.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  load data. A word load returns the whole word. A byte load returns the byte zero-extended. Always 0 for stores and errors.
- rsp_err  out  1  misaligned word access, i.e. req_byte=0 with req_addr[1:0]≠0.

## Operation
- States:
  - IDLE: req_ready=1.
  - WAIT: counting wait states.
  - RESP: rsp_valid=1.
- IDLE → WAIT on req_valid=1, or IDLE → RESP directly if WAIT_CYCLES=0.
  - On that edge, latch req_we, req_byte, req_addr and req_wdata into request registers.
  - Load the wait counter with WAIT_CYCLES-1.
- WAIT: decrement the counter each cycle. When the counter reads 0, move to RESP on the next edge.
- Entering RESP, the memory action happens on the same edge:
  - Load: rsp_rdata is registered from the latched address.
  - Word store: writes the full word.
  - Byte store: writes only the addressed lane.
  - Errored access: no write; rsp_rdata=0 and rsp_err=1.
- Byte lanes are big-endian: addr[1:0]=0 selects bits [31:24], 1 selects [23:16], 2 selects [15:8], 3 selects [7:0].
- RESP → IDLE on rsp_ready=1. rsp_valid, rsp_rdata and rsp_err stay stable while rsp_ready=0.
- Request inputs are ignored outside IDLE. There is no overlap and no queueing.
- Storage is not cleared by reset. Its contents are undefined until written.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Latency: rsp_valid rises WAIT_CYCLES+1 edges after the accepting edge (the edge where req_valid and req_ready are both high).
- Throughput: at most one request per WAIT_CYCLES+2 cycles, because the RESP→IDLE edge is spent before the next accept.
- A store is visible to any load accepted after its response edge. A load-after-store to the same address returns the new data.
- Reset mid-operation:
  - In WAIT, the pending access is dropped; no write occurs.
  - In RESP, the write has already committed.
  - In both cases the block returns to IDLE with reset output values.
- rsp_ready high outside RESP has no effect.
- req_valid held high through RESP→IDLE is accepted on the next edge in IDLE.

## Structure
- Shared package dm_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - the default ADDR_W;
  - the lane-select function mapping addr[1:0] to a 4-bit byte-enable mask, big-endian;
  - the byte-extract function.
- One sub-module, dm_bytemem: word-wide synchronous RAM with a 4-bit byte-enable write and a registered read port, instantiated once.
- The FSM, request registers, wait counter (4 bits) and error check live in the top.

## Test plan
- Reset, then word store addr=0x010, data=0xDEADBEEF, then word load addr=0x010 → rsp_rdata=0xDEADBEEF, rsp_err=0. rsp_valid rises exactly 3 edges after accept (WAIT_CYCLES=2).
- Byte stores 0x11 to 0x020, 0x22 to 0x021, 0x33 to 0x022, 0x44 to 0x023, then word load 0x020 → 0x11223344. Byte load 0x022 → 0x00000033.
- Word load addr=0x031 → rsp_err=1, rsp_rdata=0. A prior word at 0x030 (0xCAFEF00D) is unchanged when reloaded.
- Back-pressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid and rsp_rdata stable, req_ready=0. Requests presented meanwhile are not accepted.
- Assert rst during WAIT of a word store of 0x12345678 to 0x040 (previously 0x0) → outputs return to reset values; a later load of 0x040 returns 0x00000000.
- WAIT_CYCLES=0 build: store then load 0x3FC → rsp_valid one edge after each accept, load data correct, req_valid held high is accepted every 2 cycles.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states,
// default geometry and big-endian byte-lane mapping.
package dm_pkg;

    localparam int ADDR_W_DEF = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Byte 0 of a word is its most significant lane.
    function automatic logic [3:0] lane_mask(input logic [1:0] a);
        logic [3:0] m;
        case (a)
            2'd0:    m = 4'b1000;
            2'd1:    m = 4'b0100;
            2'd2:    m = 4'b0010;
            default: m = 4'b0001;
        endcase
        return m;
    endfunction

    function automatic logic [7:0] byte_extract(input logic [31:0] w, input logic [1:0] a);
        logic [7:0] b;
        case (a)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dm_bytemem.sv
// Word-wide RAM with per-byte write enables and an enabled, registered read port.
// Latency: read data valid one edge after re; writes commit on the same edge.
// Backpressure: none; the caller sequences accesses.
module dm_bytemem #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/dm_responder.sv
// Memory-side end of the data port: one load/store at a time over valid/ready.
// Latency: response WAIT_CYCLES+1 edges after accept, counting the accept edge.
// Backpressure: response held stable until rsp_ready; requests refused outside IDLE.
module dm_responder
    import dm_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_byte,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic              we_q, byte_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic              req_err, enter_resp;
    logic              m_we, m_byte, m_err;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata, ram_rdata;

    assign req_err = !req_byte && (req_addr[1:0] != 2'd0);

    // With zero wait states the access fires on the accept edge, before the
    // request registers hold anything, so the RAM is fed from the live inputs.
    assign enter_resp = (state == IDLE && req_valid && WAIT_CYCLES == 0) ||
                        (state == WAIT && cnt == 4'd0);
    assign m_we    = (state == IDLE) ? req_we    : we_q;
    assign m_byte  = (state == IDLE) ? req_byte  : byte_q;
    assign m_err   = (state == IDLE) ? req_err   : err_q;
    assign m_addr  = (state == IDLE) ? req_addr  : addr_q;
    assign m_wdata = (state == IDLE) ? req_wdata : wdata_q;

    dm_bytemem #(.AW(ADDR_W - 2)) u_mem (
        .clk   (clk),
        .we    (enter_resp && m_we && !m_err && !rst),
        .re    (enter_resp && !rst),
        .be    (m_byte ? lane_mask(m_addr[1:0]) : 4'hF),
        .addr  (m_addr[ADDR_W-1:2]),
        .wdata (m_byte ? {4{m_wdata[7:0]}} : m_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        byte_q  <= req_byte;
                        err_q   <= req_err;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt     <= CNT_INIT;
                        state   <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_err   = (state == RESP) && err_q;
    assign rsp_rdata = (state == RESP && !we_q && !err_q)
                     ? (byte_q ? {24'h0, byte_extract(ram_rdata, addr_q[1:0])} : ram_rdata)
                     : 32'h0;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance
// share request stimulus; sel0 steers req_valid and the observed outputs.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic        req_byte = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_ready = 1'b0;
    logic        sel0 = 1'b0;

    logic        rv2, rv0;
    logic        req_ready2, rsp_valid2, rsp_err2;
    logic        req_ready0, rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata2, rsp_rdata0;
    logic        o_rdy, o_vld, o_err;
    logic [31:0] o_dat;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign rv2   = req_valid && !sel0;
    assign rv0   = req_valid && sel0;
    assign o_rdy = sel0 ? req_ready0 : req_ready2;
    assign o_vld = sel0 ? rsp_valid0 : rsp_valid2;
    assign o_err = sel0 ? rsp_err0   : rsp_err2;
    assign o_dat = sel0 ? rsp_rdata0 : rsp_rdata2;

    dm_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(rv2), .req_ready(req_ready2), .req_we(req_we), .req_byte(req_byte),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2)
    );

    dm_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(rv0), .req_ready(req_ready0), .req_we(req_we), .req_byte(req_byte),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called at a negedge; returns at the first negedge where rsp_valid is seen.
    task automatic issue(input logic we, input logic bt, input logic [9:0] a,
                         input logic [31:0] d, output int lat);
        int n;
        req_we = we; req_byte = bt; req_addr = a; req_wdata = d; req_valid = 1'b1;
        n = 0;
        while (!o_rdy && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!o_vld && lat < 20) begin @(negedge clk); lat++; end
    endtask

    task automatic complete();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic xfer(input string tag, input logic we, input logic bt, input logic [9:0] a,
                        input logic [31:0] d, input logic [31:0] exp_dat, input logic exp_err);
        int lat;
        issue(we, bt, a, d, lat);
        check({tag, "_lat"}, lat, sel0 ? 32'd1 : 32'd3);
        check({tag, "_dat"}, o_dat, exp_dat);
        check({tag, "_err"}, {31'h0, o_err}, {31'h0, exp_err});
        complete();
    endtask

    initial begin
        int lat;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {31'h0, o_rdy}, 32'd1);
        check("rst_rsp_valid", {31'h0, o_vld}, 32'd0);
        check("rst_rsp_rdata", o_dat, 32'h0);
        check("rst_rsp_err",   {31'h0, o_err}, 32'd0);

        // Word store / load
        xfer("st_w010", 1'b1, 1'b0, 10'h010, 32'hDEADBEEF, 32'h0, 1'b0);
        xfer("ld_w010", 1'b0, 1'b0, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0);

        // Big-endian byte lanes; upper store bits must be ignored
        xfer("st_b020", 1'b1, 1'b1, 10'h020, 32'hAAAAAA11, 32'h0, 1'b0);
        xfer("st_b021", 1'b1, 1'b1, 10'h021, 32'h55555522, 32'h0, 1'b0);
        xfer("st_b022", 1'b1, 1'b1, 10'h022, 32'hFFFFFF33, 32'h0, 1'b0);
        xfer("st_b023", 1'b1, 1'b1, 10'h023, 32'h00000044, 32'h0, 1'b0);
        xfer("ld_w020", 1'b0, 1'b0, 10'h020, 32'h0, 32'h11223344, 1'b0);
        xfer("ld_b022", 1'b0, 1'b1, 10'h022, 32'h0, 32'h00000033, 1'b0);
        xfer("ld_b020", 1'b0, 1'b1, 10'h020, 32'h0, 32'h00000011, 1'b0);
        xfer("st_b021b", 1'b1, 1'b1, 10'h021, 32'h000000EE, 32'h0, 1'b0);
        xfer("ld_w020b", 1'b0, 1'b0, 10'h020, 32'h0, 32'h11EE3344, 1'b0);

        // Misaligned word accesses
        xfer("st_w030", 1'b1, 1'b0, 10'h030, 32'hCAFEF00D, 32'h0, 1'b0);
        xfer("ld_w031", 1'b0, 1'b0, 10'h031, 32'h0, 32'h0, 1'b1);
        xfer("st_w032", 1'b1, 1'b0, 10'h032, 32'hFFFFFFFF, 32'h0, 1'b1);
        xfer("ld_w030", 1'b0, 1'b0, 10'h030, 32'h0, 32'hCAFEF00D, 1'b0);

        // Back-pressure with a competing request presented during RESP
        issue(1'b0, 1'b0, 10'h010, 32'h0, lat);
        check("bp_lat", lat, 32'd3);
        req_we = 1'b1; req_byte = 1'b0; req_addr = 10'h010; req_wdata = 32'h0BADF00D;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", {31'h0, o_vld}, 32'd1);
            check("bp_rsp_rdata", o_dat, 32'hDEADBEEF);
            check("bp_req_ready", {31'h0, o_rdy}, 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        complete();
        xfer("bp_reload", 1'b0, 1'b0, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0);

        // Reset during WAIT drops the pending store
        xfer("st_w040z", 1'b1, 1'b0, 10'h040, 32'h0, 32'h0, 1'b0);
        req_we = 1'b1; req_byte = 1'b0; req_addr = 10'h040; req_wdata = 32'h12345678;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_wait_rdy", {31'h0, o_rdy}, 32'd0);
        rst = 1'b1;
        #2;
        check("mid_rst_rdy",   {31'h0, o_rdy}, 32'd1);
        check("mid_rst_vld",   {31'h0, o_vld}, 32'd0);
        check("mid_rst_rdata", o_dat, 32'h0);
        check("mid_rst_err",   {31'h0, o_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        xfer("ld_w040", 1'b0, 1'b0, 10'h040, 32'h0, 32'h0, 1'b0);

        // Zero-wait-state instance
        sel0 = 1'b1;
        @(negedge clk);
        xfer("z_st_3fc", 1'b1, 1'b0, 10'h3FC, 32'hA5C30F96, 32'h0, 1'b0);
        xfer("z_ld_3fc", 1'b0, 1'b0, 10'h3FC, 32'h0, 32'hA5C30F96, 1'b0);
        xfer("z_st_b3ff", 1'b1, 1'b1, 10'h3FF, 32'h00000077, 32'h0, 1'b0);
        xfer("z_ld_b3ff", 1'b0, 1'b1, 10'h3FF, 32'h0, 32'h00000077, 1'b0);

        req_we = 1'b0; req_byte = 1'b0; req_addr = 10'h3FC; req_valid = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("z_tput_vld", {31'h0, o_vld}, (i % 2 == 1) ? 32'd1 : 32'd0);
            check("z_tput_rdy", {31'h0, o_rdy}, (i % 2 == 1) ? 32'd0 : 32'd1);
            if (i % 2 == 1) check("z_tput_dat", o_dat, 32'hA5C30F77);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
